temp_sample_sequencer: RTL
==========================

// Module: temp_sample_sequencer
// PURPOSE
//   Upstream feeder for the BRAM temperature-history stage. Issues periodic ADC
//   conversion requests and oversamples N raw codes per period. Converts the mean
//   code to an 8-bit degC value and emits it as a one-cycle new_temp/new_temp_valid
//   pair, which the history/statistics block consumes.
// PARAMETERS
//   SAMPLE_PERIOD    100_000_000  clk cycles between sample-set starts (>=2)
//   OVERSAMPLE_LOG2  2            raw conversions per output = 2**OVERSAMPLE_LOG2
//   ADC_WIDTH        12           raw ADC code width
//   GAIN_Q8          32           conversion gain, unsigned Q8 (32 = 0.125 degC/LSB)
//   OFFSET           273          subtracted after scaling (Kelvin -> degC)
//   TIMEOUT          1023         max cycles adc_req may wait for adc_ack
// PORTS
//   clk             in   1          system clock, all logic on rising edge
//   rst             in   1          synchronous, active-high reset
//   enable          in   1          1 = period timer runs; 0 = timer held at 0
//   adc_req         out  1          conversion request, held until acked
//   adc_ack         in   1          conversion complete; adc_data valid this cycle
//   adc_data        in   ADC_WIDTH  raw conversion code
//   new_temp        out  8          converted temperature, degC, saturated 0..255
//   new_temp_valid  out  1          one-cycle strobe, new_temp updated
//   timeout_err     out  1          sticky: ack not received within TIMEOUT
//   overrun_err     out  1          sticky: period tick arrived while busy
//   err_clr         in   1          clears both sticky flags (rst also clears)
// BEHAVIOUR
//   Reset: adc_req=0, new_temp=0, new_temp_valid=0, both err=0, state=IDLE,
//     period counter=0, sample counter=0, accumulator=0. Reset mid-set aborts the set.
//     adc_req is low from the first edge with rst=1.
//   Period timer: counts 0..SAMPLE_PERIOD-1 while enable=1 and wraps. tick=1 on the
//     cycle the count equals SAMPLE_PERIOD-1. enable=0 forces count to 0 but does not
//     abort an in-progress set.
//   FSM IDLE: on tick -> clear acc and sample count, go REQ.
//   FSM REQ: adc_req=1 and wait counter increments each cycle.
//     On adc_ack=1: acc += adc_data, sample count++, adc_req=0 on next edge.
//     If the count reaches 2**OVERSAMPLE_LOG2 go CALC, else go GAP.
//     On wait counter == TIMEOUT with no ack: adc_req=0, timeout_err=1, set discarded,
//     no strobe, go IDLE.
//   FSM GAP: one cycle with adc_req=0, then REQ. Every conversion gets a fresh request.
//   FSM CALC: avg = acc >> OVERSAMPLE_LOG2 (truncate). acc is ADC_WIDTH+OVERSAMPLE_LOG2
//     bits wide. t = ((avg*GAIN_Q8) >> 8) - OFFSET, computed signed with no
//     intermediate overflow. t<0 -> 0; t>255 -> 255. Go OUT.
//   FSM OUT: new_temp <= t, new_temp_valid=1 for exactly this cycle, then IDLE.
//     new_temp holds until the next OUT.
//   Latency: final adc_ack sampled at edge N -> new_temp_valid high in cycle N+2.
//   Overrun: tick in any state other than IDLE sets overrun_err. That tick is dropped
//     and the current set continues.
//   Sticky flags: err_clr=1 clears both. If set and clear occur in the same cycle, set wins.
//   adc_ack while adc_req=0 is ignored.
// TESTING
//   1. Ack with 2384 four times -> new_temp=25 (0x19), valid high exactly 1 cycle,
//      2 cycles after the last ack.
//   2. Codes 2400,2408,2416,2424 -> avg 2412 -> new_temp=28. Codes 2384,2385,2386,2388
//      -> avg 2385 (truncated) -> 25.
//   3. Code 0 x4 -> new_temp=0 (low saturation). With OFFSET=0, code 4095 x4 -> 255
//      (high saturation).
//   4. Never ack -> adc_req drops after TIMEOUT=1023 cycles, timeout_err=1, no valid;
//      err_clr pulse -> 0.
//   5. SAMPLE_PERIOD=8, ack delay 10 cycles -> overrun_err=1, current set still
//      produces its output.
//   6. rst asserted in REQ with adc_req=1 -> adc_req=0 next edge, all outputs at reset
//      values, no stray valid.

Source files
------------

// File: rtl/temp_sample_sequencer.sv
// Periodic ADC oversampling sequencer: requests 2**OVERSAMPLE_LOG2 conversions per
// period, averages them and emits a saturated 8-bit degC value as a one-cycle strobe.
module temp_sample_sequencer #(
  parameter int SAMPLE_PERIOD   = 100_000_000,
  parameter int OVERSAMPLE_LOG2 = 2,
  parameter int ADC_WIDTH       = 12,
  parameter int GAIN_Q8         = 32,
  parameter int OFFSET          = 273,
  parameter int TIMEOUT         = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 adc_req,
  input  logic                 adc_ack,
  input  logic [ADC_WIDTH-1:0] adc_data,
  output logic [7:0]           new_temp,
  output logic                 new_temp_valid,
  output logic                 timeout_err,
  output logic                 overrun_err,
  input  logic                 err_clr
);

  // state | meaning
  // IDLE  | waiting for period tick
  // REQ   | adc_req high, waiting for ack or timeout
  // GAP   | one idle cycle between conversions
  // CALC  | average, scale, saturate into new_temp
  // OUT   | new_temp_valid strobe

  localparam int PCW = $clog2(SAMPLE_PERIOD);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int SCW = OVERSAMPLE_LOG2 + 1;
  localparam int AW  = ADC_WIDTH + OVERSAMPLE_LOG2;
  localparam int NS  = 1 << OVERSAMPLE_LOG2;

  typedef enum logic [2:0] {IDLE, REQ, GAP, CALC, OUT} state_t;

  state_t                state, state_nx;
  logic [PCW-1:0]        period_cnt;
  logic                  tick;
  logic [WCW-1:0]        wait_cnt;
  logic [SCW-1:0]        sample_cnt;
  logic [AW-1:0]         acc;
  logic                  ack_ok, last_sample, timed_out;
  logic [ADC_WIDTH-1:0]  avg;
  logic [47:0]           prod;
  logic signed [47:0]    scaled;
  logic [7:0]            temp_sat;

  assign tick        = (period_cnt == PCW'(SAMPLE_PERIOD - 1));
  assign ack_ok      = (state == REQ) && adc_ack;
  assign last_sample = (sample_cnt == SCW'(NS - 1));
  assign timed_out   = (state == REQ) && !adc_ack && (wait_cnt == WCW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) period_cnt <= '0;
    else                        period_cnt <= period_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    adc_req        = 1'b0;
    new_temp_valid = 1'b0;
    case (state)
      IDLE: if (tick) state_nx = REQ;
      REQ: begin
        adc_req = 1'b1;
        if (ack_ok)         state_nx = last_sample ? CALC : GAP;
        else if (timed_out) state_nx = IDLE;
      end
      GAP:  state_nx = REQ;
      CALC: state_nx = OUT;
      OUT: begin
        new_temp_valid = 1'b1;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Wide signed intermediate so the offset subtraction can never wrap
  always_comb begin
    avg    = ADC_WIDTH'(acc >> OVERSAMPLE_LOG2);
    prod   = 48'(avg) * 48'(GAIN_Q8);
    scaled = $signed(prod >> 8) - $signed(48'(OFFSET));
    if (scaled < 0)        temp_sat = 8'd0;
    else if (scaled > 255) temp_sat = 8'd255;
    else                   temp_sat = scaled[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt   <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      new_temp   <= '0;
    end else begin
      wait_cnt <= ((state == REQ) && !adc_ack) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE && tick) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (ack_ok) begin
        acc        <= acc + AW'(adc_data);
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (state == CALC) new_temp <= temp_sat;
    end
  end

  // Sticky flags: a set in the same cycle as err_clr takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (timed_out)    timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
      if (tick && state != IDLE) overrun_err <= 1'b1;
      else if (err_clr)          overrun_err <= 1'b0;
    end
  end

endmodule
